// File: rtl/init_seq_ctrl_pkg.sv
// Shared types and constants for the init sequence controller.
package init_seq_ctrl_pkg;

    // Controller states; the numeric values are fixed so they can be compared across builds.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StDone  = 3'd3,
        StFail  = 3'd4
    } state_e;

    // Error codes reported on m_err_init_info (zero-extended).
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NACK     = 2'd1;
    localparam logic [1:0] ERR_TMO_DONE = 2'd2;
    localparam logic [1:0] ERR_TMO_RDY  = 2'd3;

    // Timer bit whose assertion means expiry; simulation mode shortens it to 16 cycles.
    function automatic int unsigned tmo_bit(input int unsigned md_sim_able,
                                            input int unsigned nb_timeout);
        return (md_sim_able != 0) ? 32'd4 : nb_timeout;
    endfunction

endpackage

// File: rtl/init_seq_ctrl_if.sv
// Step request / completion interface between the init controller and the step executor.
interface init_seq_ctrl_if #(
    parameter int unsigned WD_STEP = 3
) ();

    logic               m_step_valid;
    logic               m_step_ready;
    logic [WD_STEP-1:0] m_step_index;
    logic               s_step_done;
    logic               s_step_fail;

    // Controller side: issues requests, receives completions.
    modport master (
        output m_step_valid,
        output m_step_index,
        input  m_step_ready,
        input  s_step_done,
        input  s_step_fail
    );

    // Executor side.
    modport slave (
        input  m_step_valid,
        input  m_step_index,
        output m_step_ready,
        output s_step_done,
        output s_step_fail
    );

endinterface

// File: rtl/init_seq_timer.sv
// Free-running timeout counter with clear/enable; expires when bit NB_BIT becomes set.
module init_seq_timer #(
    parameter int unsigned NB_BIT = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [NB_BIT:0] r_cnt;

    // Counter: clear has priority over counting; no saturation since the owner leaves on expiry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = r_cnt[NB_BIT];

endmodule

// File: rtl/init_seq_ctrl.sv
// Init sequence controller: issues NB_STEP steps to an executor with per-step timeout and retry.
module init_seq_ctrl
    import init_seq_ctrl_pkg::*;
#(
    parameter int unsigned MD_SIM_ABLE = 0,
    parameter int unsigned NB_STEP     = 8,
    parameter int unsigned WD_STEP     = 3,
    parameter int unsigned NB_TIMEOUT  = 20,
    parameter int unsigned NB_RETRY    = 2,
    parameter int unsigned WD_ERR_INFO = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_reset,
    input  logic                   i_init_update,
    init_seq_ctrl_if.master        step_if,
    output logic                   o_init_busy,
    output logic                   o_init_done,
    output logic                   o_init_fail,
    output logic [WD_ERR_INFO-1:0] m_err_init_info,
    output logic [WD_STEP-1:0]     m_err_step
);

    localparam int unsigned        TMO_BIT   = tmo_bit(MD_SIM_ABLE, NB_TIMEOUT);
    localparam logic [WD_STEP-1:0] LAST_STEP = WD_STEP'(NB_STEP - 1);

    state_e                 r_state;
    logic [WD_STEP-1:0]     r_step;
    logic [1:0]             r_retry;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_fail;
    logic [WD_ERR_INFO-1:0] r_err_info;
    logic [WD_STEP-1:0]     r_err_step;

    state_e                 w_state_d;
    logic [WD_STEP-1:0]     w_step_d;
    logic [1:0]             w_retry_d;
    logic [WD_ERR_INFO-1:0] w_err_info_d;
    logic [WD_STEP-1:0]     w_err_step_d;
    logic                   w_tmr_clr;
    logic                   w_retry_req;
    logic [1:0]             w_code;
    logic                   w_tmo_rdy;
    logic                   w_tmo_done;

    // Handshake timeout: counts only while a request is outstanding.
    init_seq_timer #(
        .NB_BIT (TMO_BIT)
    ) u_tmr_rdy (
        .i_clk    (i_sys_clk),
        .i_reset  (i_sys_reset),
        .i_clr    (w_tmr_clr),
        .i_en     (r_state == StIssue),
        .o_expire (w_tmo_rdy)
    );

    // Completion timeout: counts only while waiting for done/fail.
    init_seq_timer #(
        .NB_BIT (TMO_BIT)
    ) u_tmr_done (
        .i_clk    (i_sys_clk),
        .i_reset  (i_sys_reset),
        .i_clr    (w_tmr_clr),
        .i_en     (r_state == StWait),
        .o_expire (w_tmo_done)
    );

    // Next-state logic: sequencing, retry decision and error capture.
    always_comb begin
        w_state_d    = r_state;
        w_step_d     = r_step;
        w_retry_d    = r_retry;
        w_err_info_d = r_err_info;
        w_err_step_d = r_err_step;
        w_tmr_clr    = 1'b0;
        w_retry_req  = 1'b0;
        w_code       = ERR_NONE;

        unique case (r_state)
            StIdle, StDone, StFail: begin
                // Start or restart: clear status and begin again at step 0.
                if (i_init_update) begin
                    w_state_d    = StIssue;
                    w_step_d     = '0;
                    w_retry_d    = '0;
                    w_err_info_d = '0;
                    w_err_step_d = '0;
                    w_tmr_clr    = 1'b1;
                end
            end
            StIssue: begin
                // A transfer on the expiry cycle still counts as accepted.
                if (r_valid && step_if.m_step_ready) begin
                    w_state_d = StWait;
                    w_tmr_clr = 1'b1;
                end else if (w_tmo_rdy) begin
                    w_retry_req = 1'b1;
                    w_code      = ERR_TMO_RDY;
                end
            end
            StWait: begin
                if (step_if.s_step_fail) begin
                    w_retry_req = 1'b1;
                    w_code      = ERR_NACK;
                end else if (step_if.s_step_done) begin
                    if (r_step == LAST_STEP) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StIssue;
                        w_step_d  = r_step + WD_STEP'(1);
                        w_retry_d = '0;
                        w_tmr_clr = 1'b1;
                    end
                end else if (w_tmo_done) begin
                    w_retry_req = 1'b1;
                    w_code      = ERR_TMO_DONE;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Shared retry path for nack and both timeouts.
        if (w_retry_req) begin
            if ({30'd0, r_retry} < NB_RETRY) begin
                w_state_d = StIssue;
                w_retry_d = r_retry + 2'd1;
                w_tmr_clr = 1'b1;
            end else begin
                w_state_d    = StFail;
                w_err_info_d = WD_ERR_INFO'(w_code);
                w_err_step_d = r_step;
            end
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            r_state    <= StIdle;
            r_step     <= '0;
            r_retry    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_err_info <= '0;
            r_err_step <= '0;
        end else begin
            r_state    <= w_state_d;
            r_step     <= w_step_d;
            r_retry    <= w_retry_d;
            r_valid    <= (w_state_d == StIssue);
            r_busy     <= (w_state_d == StIssue) || (w_state_d == StWait);
            r_done     <= (w_state_d == StDone);
            r_fail     <= (w_state_d == StFail);
            r_err_info <= w_err_info_d;
            r_err_step <= w_err_step_d;
        end
    end

    assign step_if.m_step_valid = r_valid;
    assign step_if.m_step_index = r_step;
    assign o_init_busy          = r_busy;
    assign o_init_done          = r_done;
    assign o_init_fail          = r_fail;
    assign m_err_init_info      = r_err_info;
    assign m_err_step           = r_err_step;

endmodule

// File: doc/init_seq_ctrl.md
Name: init_seq_ctrl

Overview:
- Consumer of the power-up start pulse; the receiving end of the one-shot init-update interface.
- On each start pulse, steps through NB_STEP initialisation steps, e.g. sensor/PHY configuration writes.
- Each step is issued to a downstream step executor via a valid/ready handshake, then the block waits for a done/fail completion pulse.
- Timeout and retry are applied per step. Final status is reported through done/fail flags and an error-info code.

Parameters:
- MD_SIM_ABLE, 0: 1 = timeout bit index forced to 4 (16 cycles) for simulation.
- NB_STEP, 8: number of init steps, 2..256.
- WD_STEP, 3: width of step index; must be ≥ clog2(NB_STEP).
- NB_TIMEOUT, 20: timeout bit index; expiry after 2^NB_TIMEOUT cycles in ISSUE or WAIT; max 31.
- NB_RETRY, 2: retries allowed per step before FAIL, 0..3.
- WD_ERR_INFO, 4: error-info width, ≥ 2.

Ports:
- i_sys_clk, in, 1: system clock; single clock domain.
- i_sys_reset, in, 1: synchronous, active-high reset.
- i_init_update, in, 1: start pulse; one cycle nominal, longer levels tolerated.
- m_step_valid, out, 1: step request valid.
- m_step_ready, in, 1: executor accepts request.
- m_step_index, out, WD_STEP: index of the step being requested.
- s_step_done, in, 1: one-cycle pulse, current step succeeded.
- s_step_fail, in, 1: one-cycle pulse, current step failed.
- o_init_busy, out, 1: sequence in progress.
- o_init_done, out, 1: all steps succeeded; sticky.
- o_init_fail, out, 1: sequence aborted; sticky.
- m_err_init_info, out, WD_ERR_INFO: error code.
- m_err_step, out, WD_STEP: index of the failing step.

Behaviour:
- All outputs are registered.
- Reset, synchronous, priority over everything:
  - state IDLE.
  - All outputs 0.
  - Step, retry and timeout counters 0.
- States: IDLE, ISSUE, WAIT, DONE, FAIL.
- IDLE: i_init_update=1 → ISSUE next cycle.
  - step=0, retry=0, timer=0.
  - o_init_busy=1 and m_step_valid=1 in the cycle after the pulse (latency 1).
- ISSUE:
  - m_step_valid=1; m_step_index held stable until accepted.
  - valid ∧ ready in same cycle → WAIT, timer=0, valid drops next cycle.
  - Timer expiry before ready → retry path with code 3.
- WAIT:
  - Timer increments each cycle.
  - s_step_fail → retry path with code 1.
  - Timer expiry, i.e. timer[NB_TIMEOUT]=1 → retry path with code 2.
  - s_step_done with step==NB_STEP-1 → DONE.
  - s_step_done otherwise → step+1, retry=0, timer=0, ISSUE.
  - Simultaneous done and fail: fail wins.
- Retry path:
  - retry<NB_RETRY → retry+1, timer=0, ISSUE with the same step.
  - Otherwise → FAIL with m_err_init_info=code (zero-extended) and m_err_step=step.
- Error codes: 0 none, 1 step nack, 2 completion timeout, 3 handshake timeout.
- DONE: o_init_done=1, o_init_busy=0; held until reset or restart.
- FAIL: o_init_fail=1, o_init_busy=0; error outputs held until reset or restart.
- Restart: i_init_update in DONE or FAIL → clears done, fail and error outputs, then re-enters ISSUE at step 0 (same timing as from IDLE).
- i_init_update while busy (ISSUE/WAIT): ignored; no restart.
- s_step_done or s_step_fail outside WAIT: ignored.
- Timer:
  - NB_TIMEOUT+1 bits; saturation is not needed because the state exits on expiry.
  - Effective bit index = MD_SIM_ABLE ? 4 : NB_TIMEOUT.
- Reset mid-sequence: abort at once; no request is re-issued until a new i_init_update.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0 … FAIL=4).
  - error code constants ERR_NONE / ERR_NACK / ERR_TMO_DONE / ERR_TMO_RDY.
- One natural sub-module, init_seq_timer: clear / enable / expire, parameterised by bit index, reused for both handshake and completion timeouts.

Test Plan:
All cases use MD_SIM_ABLE=1, NB_STEP=4, NB_RETRY=2.
- Happy path: pulse at T, ready held 1, done 3 cycles after each accept → valid at T+1; indices 0,1,2,3 issued in order; o_init_done=1 after the 4th done; busy=0; err=0.
- Nack then success: fail pulse on step 1, done on its retry → step 1 issued twice; sequence completes; o_init_done=1.
- Persistent nack: fail on every attempt of step 2 → step 2 issued 3 times; then o_init_fail=1, m_err_init_info=1, m_err_step=2.
- Ready stuck 0 → 3 × 16-cycle waits; then FAIL, err=3, m_err_step=0.
- No completion after accept → FAIL after 3 timeouts, err=2.
- Edge cases:
  - done+fail in the same cycle → treated as fail.
  - Pulse during WAIT → ignored.
  - Pulse in FAIL → flags cleared; restart at step 0.
  - Reset asserted in WAIT → all outputs 0 next cycle.
